// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared access-size encodings and FSM state type for the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-enable generation, store-lane replication and load
//               extract/sign-or-zero extension for a 32-bit data path.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // Size 2'b11 falls through to the word path.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage load/store unit running one req/gnt/rvalid data
//               bus transaction per access. Optional MISALIGN_EXC_EN macro
//               flags misaligned half/word accesses instead of issuing them.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_d_size,
    input  logic                  i_d_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [3:0]            o_dmem_be,
    output logic [31:0]           o_dmem_wdata,
    input  logic                  i_dmem_gnt,
    input  logic                  i_dmem_rvalid,
    input  logic [31:0]           i_dmem_rdata
);

    lsu_state_e            r_state;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;

    logic                  w_idle;
    logic                  w_op;
    logic                  w_we;
    logic                  w_misaligned;
    logic [1:0]            w_sel_size;
    logic [1:0]            w_sel_lo;
    logic                  w_sel_uns;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata_fmt;

    assign w_idle = (r_state == IDLE);
    assign w_op   = i_mem_read | i_mem_write;
    // A simultaneous read and write request is serviced as a load.
    assign w_we   = i_mem_write & ~i_mem_read;

`ifdef MISALIGN_EXC_EN
    assign w_misaligned = w_idle & w_op &
                          (((i_d_size == SIZE_HALF) & i_addr[0]) |
                           (((i_d_size == SIZE_WORD) | (i_d_size == 2'b11)) &
                            (i_addr[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    // The aligner sees live inputs while capturing, captured values afterwards.
    assign w_sel_size = w_idle ? i_d_size     : r_size;
    assign w_sel_lo   = w_idle ? i_addr[1:0]  : r_addr[1:0];
    assign w_sel_uns  = w_idle ? i_d_unsigned : r_uns;

    lsu_align u_align (
        .i_size     (w_sel_size),
        .i_addr_lo  (w_sel_lo),
        .i_unsigned (w_sel_uns),
        .i_wdata    (i_wdata),
        .i_rdata    (i_dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata_fmt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_size  <= SIZE_BYTE;
            r_uns   <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_op && !w_misaligned) begin
                        r_addr  <= i_addr;
                        r_size  <= i_d_size;
                        r_uns   <= i_d_unsigned;
                        r_we    <= w_we;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (i_dmem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= r_we ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (i_dmem_rvalid) begin
                        r_rdata <= w_rdata_fmt;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign o_stall      = (w_idle & w_op & ~w_misaligned) |
                          (r_state == REQ) | (r_state == WAIT);
    assign o_misaligned = w_misaligned;
    assign o_rdata      = r_rdata;
    assign o_dmem_req   = r_req;
    assign o_dmem_we    = r_we;
    assign o_dmem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign o_dmem_be    = r_be;
    assign o_dmem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mem_read    (mem_read),
        .i_mem_write   (mem_write),
        .i_d_size      (d_size),
        .i_d_unsigned  (d_unsigned),
        .i_addr        (addr),
        .i_wdata       (wdata),
        .o_rdata       (rdata),
        .o_stall       (stall),
        .o_misaligned  (misaligned),
        .o_dmem_req    (dmem_req),
        .o_dmem_we     (dmem_we),
        .o_dmem_addr   (dmem_addr),
        .o_dmem_be     (dmem_be),
        .o_dmem_wdata  (dmem_wdata),
        .i_dmem_gnt    (dmem_gnt),
        .i_dmem_rvalid (dmem_rvalid),
        .i_dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic op_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_idle(); d_size = 2'b00; d_unsigned = 1'b0;
        addr = 32'd0; wdata = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        check("rst_req",   {31'd0, dmem_req},   32'd0);
        check("rst_stall", {31'd0, stall},      32'd0);
        check("rst_rdata", rdata,               32'd0);
        check("rst_addr",  dmem_addr,           32'd0);
        check("rst_be",    {28'd0, dmem_be},    32'd0);
        check("rst_wdata", dmem_wdata,          32'd0);
        check("rst_mis",   {31'd0, misaligned}, 32'd0);

        // LB 0x103, sign-extended top byte
        mem_read = 1'b1; d_size = 2'b00; d_unsigned = 1'b0; addr = 32'h0000_0103;
        #1 check("lb_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lb_req",   {31'd0, dmem_req}, 32'd1);
        check("lb_be",    {28'd0, dmem_be},  32'h8);
        check("lb_addr",  dmem_addr,         32'h0000_0100);
        check("lb_we",    {31'd0, dmem_we},  32'd0);
        dmem_gnt = 1'b1;
        tick();
        check("lb_wait_req",   {31'd0, dmem_req}, 32'd0);
        check("lb_wait_stall", {31'd0, stall},    32'd1);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
        tick();
        dmem_rvalid = 1'b0;
        check("lb_rdata", rdata,             32'hFFFF_FF80);
        check("lb_resp_stall", {31'd0, stall}, 32'd0);
        op_idle();
        tick();

        // LHU 0x102
        mem_read = 1'b1; d_size = 2'b01; d_unsigned = 1'b1; addr = 32'h0000_0102;
        tick();
        check("lhu_be", {28'd0, dmem_be}, 32'hC);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000; tick(); dmem_rvalid = 1'b0;
        check("lhu_rdata", rdata, 32'h0000_8001);
        op_idle(); tick();

        // LH same data, signed
        mem_read = 1'b1; d_unsigned = 1'b0;
        tick();
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1; tick(); dmem_rvalid = 1'b0;
        check("lh_rdata", rdata, 32'hFFFF_8001);
        op_idle(); tick();

        // SB 0x201: two stalled cycles, o_rdata untouched
        mem_write = 1'b1; d_size = 2'b00; addr = 32'h0000_0201; wdata = 32'h0000_00AB;
        #1 check("sb_idle_stall", {31'd0, stall}, 32'd1);
        tick();
        check("sb_be",    {28'd0, dmem_be},  32'h2);
        check("sb_wdata", dmem_wdata,        32'hABAB_ABAB);
        check("sb_we",    {31'd0, dmem_we},  32'd1);
        check("sb_stall", {31'd0, stall},    32'd1);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        check("sb_resp_stall", {31'd0, stall},    32'd0);
        check("sb_resp_req",   {31'd0, dmem_req}, 32'd0);
        check("sb_rdata_keep", rdata,             32'hFFFF_8001);
        op_idle(); tick();

        // SH 0x302 replicates halfword
        mem_write = 1'b1; d_size = 2'b01; addr = 32'h0000_0302; wdata = 32'h1234_5678;
        tick();
        check("sh_be",    {28'd0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata,       32'h5678_5678);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        op_idle(); tick();

        // LW with delayed grant; stray rvalid in REQ must be ignored
        mem_read = 1'b1; d_size = 2'b10; addr = 32'h0000_0300;
        tick();
        for (int i = 0; i < 5; i++) begin
            dmem_rvalid = (i == 2); dmem_rdata = 32'h5555_5555;
            check("lw_hold_req",   {31'd0, dmem_req}, 32'd1);
            check("lw_hold_addr",  dmem_addr,         32'h0000_0300);
            check("lw_hold_be",    {28'd0, dmem_be},  32'hF);
            check("lw_hold_stall", {31'd0, stall},    32'd1);
            tick();
        end
        dmem_rvalid = 1'b0;
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        tick();
        check("lw_wait_stall", {31'd0, stall}, 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; tick(); dmem_rvalid = 1'b0;
        check("lw_rdata", rdata,               32'hDEAD_BEEF);
        check("lw_resp_stall", {31'd0, stall}, 32'd0);
        op_idle(); tick();

        // Reset while in WAIT, late rvalid ignored
        mem_read = 1'b1; d_size = 2'b10; addr = 32'h0000_0400;
        tick();
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        rst = 1'b1; op_idle(); tick(); rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678; tick(); dmem_rvalid = 1'b0;
        check("rstw_req",   {31'd0, dmem_req}, 32'd0);
        check("rstw_stall", {31'd0, stall},    32'd0);
        check("rstw_rdata", rdata,             32'd0);

        // LW at 0x102
        mem_read = 1'b1; d_size = 2'b10; addr = 32'h0000_0102;
        #1;
`ifdef MISALIGN_EXC_EN
        check("mis_flag",  {31'd0, misaligned}, 32'd1);
        check("mis_stall", {31'd0, stall},      32'd0);
        tick();
        check("mis_noreq", {31'd0, dmem_req},   32'd0);
`else
        check("mis_flag",  {31'd0, misaligned}, 32'd0);
        check("mis_stall", {31'd0, stall},      32'd1);
        tick();
        check("mis_req",   {31'd0, dmem_req},   32'd1);
        check("mis_addr",  dmem_addr,           32'h0000_0100);
        dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D; tick(); dmem_rvalid = 1'b0;
        check("mis_rdata", rdata,               32'hCAFE_F00D);
`endif
        op_idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
